// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the MIPS instruction fetch unit: next-PC select codes,
// fetch FSM states, instruction field positions and branch/jump target helpers.
package ifu_fetch_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        NPC_SEQ  = 2'b00,
        NPC_J    = 2'b01,
        NPC_BGTZ = 2'b10,
        NPC_BEQ  = 2'b11
    } npc_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        ISSUE = 2'b10
    } fetch_state_t;

    localparam int OP_MSB     = 31;
    localparam int OP_LSB     = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int INDEX_MSB  = 25;
    localparam int INDEX_LSB  = 0;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BGTZ  = 6'h07;

    // Word offset of a branch: sign-extended imm16 scaled by 4.
    function automatic logic [31:0] branch_offset(input logic [INDEX_MSB:0] index);
        return {{14{index[IMM_MSB]}}, index[IMM_MSB:IMM_LSB], 2'b00};
    endfunction

    // Jump target stays inside the 256 MB region of the delay-free pc + 4.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [INDEX_MSB:0] index);
        return {pc_plus4[31:28], index[INDEX_MSB:INDEX_LSB], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction memory request/acknowledge bus between the fetch unit and imem.
interface ifu_fetch_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/ifu_fetch_npc.sv
// Combinational next-PC calculation; only the low 26 instruction bits matter,
// since the opcode is already folded into the decoder's npc_sel.
module ifu_npc
    import ifu_fetch_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr,
    input  logic [1:0]  npc_sel,
    input  logic        gtz_flag,
    output logic [31:0] npc
);

    logic [31:0] branch_target;
    logic [31:0] jump_addr;

    assign branch_target = pc_plus4 + branch_offset(instr);
    assign jump_addr     = jump_target(pc_plus4, instr);

    always_comb begin
        npc = pc_plus4;
        case (npc_sel_t'(npc_sel))
            NPC_SEQ:  npc = pc_plus4;
            NPC_J:    npc = jump_addr;
            NPC_BGTZ: npc = gtz_flag ? branch_target : pc_plus4;
            NPC_BEQ:  npc = branch_target;
            default:  npc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, fetches one word per instruction over the
// imem req/ack bus and applies the decoder's next-PC choice on commit.
// Define IFU_PERF_EN to add the retired-instruction counter port icount.
module ifu_fetch
    import ifu_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    ifu_fetch_if.master        imem,
    input  logic [1:0]         npc_sel,
    input  logic               gtz_flag,
    input  logic               commit,
    output logic [31:0]        instr,
    output logic [5:0]         op,
    output logic [5:0]         funct,
    output logic               instr_valid,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]        icount
`endif
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic         load_ir;
    logic         load_pc;
    logic [31:0]  npc;

    assign pc_plus4  = pc + 32'd4;
    assign imem.addr = pc;
    assign op        = instr[OP_MSB:OP_LSB];
    assign funct     = instr[FUNCT_MSB:FUNCT_LSB];

    ifu_npc u_npc (
        .pc_plus4 (pc_plus4),
        .instr    (instr[INDEX_MSB:INDEX_LSB]),
        .npc_sel  (npc_sel),
        .gtz_flag (gtz_flag),
        .npc      (npc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ack is only honoured while requesting and commit only while issuing,
    // so stray pulses in the other states leave everything untouched.
    always_comb begin
        state_next  = state;
        load_ir     = 1'b0;
        load_pc     = 1'b0;
        imem.req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem.req = 1'b1;
                if (imem.ack) begin
                    load_ir    = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (commit) begin
                    load_pc    = 1'b1;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc    <= RESET_PC;
            instr <= '0;
        end else begin
            if (load_pc) begin
                pc <= npc;
            end
            if (load_ir) begin
                instr <= imem.rdata;
            end
        end
    end

`ifdef IFU_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            icount <= '0;
        end else if (load_pc) begin
            icount <= icount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: a cycle-level reference model compared every
// cycle, plus directed literal expectations along the fetch/commit sequence.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  npc_sel = 2'b00;
    logic        gtz_flag = 1'b0;
    logic        commit = 1'b0;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef IFU_PERF_EN
    logic [31:0] icount;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    ifu_fetch_if imem_bus ();

    ifu_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem_bus),
        .npc_sel     (npc_sel),
        .gtz_flag    (gtz_flag),
        .commit      (commit),
        .instr       (instr),
        .op          (op),
        .funct       (funct),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
`ifdef IFU_PERF_EN
        ,
        .icount      (icount)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = one cycle after reset, 1 = waiting for the
    // fetched word, 2 = word held until the datapath commits it.
    logic [31:0] m_pc    = 32'h0000_3000;
    logic [31:0] m_ir    = 32'h0;
    logic [31:0] m_count = 32'h0;
    int          m_phase = 0;

    function automatic logic [31:0] model_npc(input logic [31:0] cur_pc,
                                              input logic [31:0] word,
                                              input logic [1:0]  sel,
                                              input logic        gtz);
        logic [31:0] seq_addr;
        logic [31:0] br_addr;
        logic [31:0] j_addr;
        logic [15:0] imm;
        int          offset;
        seq_addr = cur_pc + 32'd4;
        imm      = word[15:0];
        offset   = int'($signed(imm)) * 4;
        br_addr  = seq_addr + 32'(offset);
        j_addr   = (seq_addr & 32'hF000_0000) | ({6'b0, word[25:0]} << 2);
        case (sel)
            2'd1:    return j_addr;
            2'd2:    return gtz ? br_addr : seq_addr;
            2'd3:    return br_addr;
            default: return seq_addr;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_pc    = 32'h0000_3000;
            m_ir    = 32'h0;
            m_count = 32'h0;
            m_phase = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (imem_bus.ack) begin
                m_ir    = imem_bus.rdata;
                m_phase = 2;
            end
        end else if (commit) begin
            m_pc    = model_npc(m_pc, m_ir, npc_sel, gtz_flag);
            m_count = m_count + 32'd1;
            m_phase = 1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check_output("model imem_req", 32'(imem_bus.req), 32'(m_phase == 1));
            check_output("model instr_valid", 32'(instr_valid), 32'(m_phase == 2));
            check_output("model imem_addr", imem_bus.addr, m_pc);
            check_output("model pc", pc, m_pc);
            check_output("model pc_plus4", pc_plus4, m_pc + 32'd4);
            check_output("model instr", instr, m_ir);
            check_output("model op", 32'(op), m_ir >> 26);
            check_output("model funct", 32'(funct), m_ir & 32'h3F);
`ifdef IFU_PERF_EN
            check_output("model icount", icount, m_count);
`endif
        end
    end

    // Drives one cycle of inputs and returns at the following falling edge.
    task automatic apply_stimulus(input logic r, input logic a, input logic [31:0] d,
                                  input logic c, input logic [1:0] s, input logic g);
        #1;
        rst            = r;
        imem_bus.ack   = a;
        imem_bus.rdata = d;
        commit         = c;
        npc_sel        = s;
        gtz_flag       = g;
        @(negedge clk);
    endtask

    task automatic fetch_word(input logic [31:0] d);
        apply_stimulus(1'b1, 1'b1, d, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic do_commit(input logic [1:0] s, input logic g);
        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1, s, g);
    endtask

    task automatic run_one(input logic [31:0] d, input logic [1:0] s, input logic g);
        fetch_word(d);
        do_commit(s, g);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 100000");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        imem_bus.ack   = 1'b0;
        imem_bus.rdata = 32'h0;
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0);
        check_en = 1'b1;
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0);
        check_output("reset pc", pc, 32'h0000_3000);
        check_output("reset instr_valid", 32'(instr_valid), 32'h0);
        check_output("reset imem_req", 32'(imem_bus.req), 32'h0);
        check_output("reset op", 32'(op), 32'h0);
        check_output("reset funct", 32'(funct), 32'h0);
`ifdef IFU_PERF_EN
        check_output("reset icount", icount, 32'h0);
`endif

        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0);
        check_output("first req", 32'(imem_bus.req), 32'h1);
        check_output("first addr", imem_bus.addr, 32'h0000_3000);
        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0);
        check_output("valid before ack", 32'(instr_valid), 32'h0);
        fetch_word(32'h8D09_002A);
        check_output("valid after ack", 32'(instr_valid), 32'h1);
        check_output("op from rdata", 32'(op), 32'h23);
        check_output("funct from rdata", 32'(funct), 32'h2A);

        do_commit(2'b00, 1'b0);
        check_output("seq addr", imem_bus.addr, 32'h0000_3004);
`ifdef IFU_PERF_EN
        check_output("icount after 1", icount, 32'h1);
`endif
        run_one(32'h0000_0000, 2'b00, 1'b0);
        check_output("seq to 3008", pc, 32'h0000_3008);
        run_one(32'h0800_0C10, 2'b01, 1'b0);
        check_output("jump pc", pc, 32'h0000_3040);
        run_one(32'h1000_FFF3, 2'b11, 1'b0);
        check_output("beq back pc", pc, 32'h0000_3010);
        run_one(32'h1000_FFFE, 2'b11, 1'b0);
        check_output("beq taken pc", pc, 32'h0000_300C);
        run_one(32'h0000_0000, 2'b00, 1'b0);
        run_one(32'h1C00_FFFE, 2'b10, 1'b0);
        check_output("bgtz not taken", pc, 32'h0000_3014);
        run_one(32'h1000_FFFE, 2'b11, 1'b0);
        check_output("beq to 3010", pc, 32'h0000_3010);
        run_one(32'h1C00_FFFE, 2'b10, 1'b1);
        check_output("bgtz taken", pc, 32'h0000_300C);

        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 1'b0);
        check_output("spurious commit pc", pc, 32'h0000_300C);
        check_output("spurious commit req", 32'(imem_bus.req), 32'h1);
        fetch_word(32'h2108_0001);
        fetch_word(32'hFFFF_FFFF);
        check_output("spurious ack instr", instr, 32'h2108_0001);
        check_output("spurious ack valid", 32'(instr_valid), 32'h1);
        do_commit(2'b00, 1'b0);
        check_output("after spurious pc", pc, 32'h0000_3010);

        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0);
        check_output("mid reset req", 32'(imem_bus.req), 32'h0);
        check_output("mid reset pc", pc, 32'h0000_3000);
        check_output("mid reset valid", 32'(instr_valid), 32'h0);
        apply_stimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'b00, 1'b0);
        check_output("late ack valid", 32'(instr_valid), 32'h0);
        check_output("late ack instr", instr, 32'h0);
        check_output("refetch req", 32'(imem_bus.req), 32'h1);
        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0);
        check_output("refetch waiting", 32'(imem_bus.req), 32'h1);

        run_one(32'h1000_8000, 2'b11, 1'b0);
        check_output("far branch pc", pc, 32'hFFFE_3004);
        run_one(32'h0BFF_FFFF, 2'b01, 1'b0);
        check_output("top jump pc", pc, 32'hFFFF_FFFC);
        run_one(32'h0000_0000, 2'b00, 1'b0);
        check_output("wrap addr", imem_bus.addr, 32'h0000_0000);
        check_output("wrap pc_plus4", pc_plus4, 32'h0000_0004);
`ifdef IFU_PERF_EN
        check_output("icount after reset", icount, 32'h3);
`endif

        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0);
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
